pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 17 +
 rtl/stall_prio_enc.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states,
// exception cause encodings and the NOP used for bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_HANDLER = 2'b10
    } haz_state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_INSTR = 2'b01;
    localparam logic [1:0] CAUSE_MEM   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/stall_prio_enc.sv
// Highest-set-bit encoder: index of the oldest stage asking to hold,
// plus a valid flag when any request bit is set.
module stall_prio_enc #(
    parameter int W  = 5,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble control with TLB-miss drain and handler entry.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int MEM_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  tlb_miss_instr,
    input  logic                  tlb_miss_mem,
    input  logic                  iret,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  exc_take,
    output logic [1:0]            exc_cause,
    output logic [1:0]            fsm_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           miss_count
`endif
);

    localparam int IW = $clog2(NUM_STAGES);

    haz_state_e      state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [IW-1:0]   cnt_q, cnt_d;

    logic [IW-1:0]   drain_m;
    logic [IW-1:0]   target;
    logic [NUM_STAGES-1:0] mask;
    logic [IW-1:0]   k_idx;
    logic            k_vld;

    logic            take;
    logic            frz_v;
    logic [IW-1:0]   frz_idx;
    logic [NUM_STAGES-1:0] en_c, bub_c;

    // Frozen boundary while draining: MEM_STAGE for data miss, fetch for instr.
    assign drain_m = (cause_q == CAUSE_MEM) ? IW'(MEM_STAGE) : '0;
    assign target  = IW'(NUM_STAGES - 1) - drain_m;

    always_comb begin
        mask = '1;
        if (state_q == ST_DRAIN) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                mask[j] = (j > int'(drain_m));
            end
        end
    end

    stall_prio_enc #(
        .W  (NUM_STAGES),
        .IW (IW)
    ) u_enc (
        .req_i   (stall_req & mask),
        .idx_o   (k_idx),
        .valid_o (k_vld)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        frz_v   = k_vld;
        frz_idx = k_idx;
        case (state_q)
            ST_DRAIN: begin
                if (cnt_q == target) begin
                    take    = 1'b1;
                    frz_v   = 1'b0;
                    state_d = ST_HANDLER;
                    cnt_d   = '0;
                end else begin
                    frz_v = 1'b1;
                    if (!k_vld) begin
                        frz_idx = drain_m;
                        cnt_d   = cnt_q + IW'(1);
                    end
                end
            end
            ST_HANDLER: begin
                if (iret) begin
                    state_d = ST_RUN;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                if (tlb_miss_mem) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_MEM;
                    cnt_d   = '0;
                end else if (tlb_miss_instr) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_INSTR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        en_c  = '1;
        bub_c = '0;
        if (take) begin
            bub_c = '1;
        end else if (frz_v) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                en_c[j]  = (j > int'(frz_idx));
                bub_c[j] = (j == int'(frz_idx) + 1);
            end
        end
    end

    // Reset overrides the outputs combinationally, independent of the clock.
    assign stage_en  = reset ? en_c : '1;
    assign bubble    = reset ? bub_c : '0;
    assign exc_take  = reset & take;
    assign exc_cause = cause_q;
    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            miss_count   <= '0;
        end else begin
            if (!(&stage_en) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state_q == ST_RUN) && (state_d == ST_DRAIN)
                && (miss_count != '1)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (NUM_STAGES=5, MEM_STAGE=3).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] stall_req;
    logic       tlb_miss_instr;
    logic       tlb_miss_mem;
    logic       iret;
    logic [4:0] stage_en;
    logic [4:0] bubble;
    logic       exc_take;
    logic [1:0] exc_cause;
    logic [1:0] fsm_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] miss_count;
`endif

    pipe_hazard_ctrl #(
        .NUM_STAGES (5),
        .MEM_STAGE  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_req      (stall_req),
        .tlb_miss_instr (tlb_miss_instr),
        .tlb_miss_mem   (tlb_miss_mem),
        .iret           (iret),
        .stage_en       (stage_en),
        .bubble         (bubble),
        .exc_take       (exc_take),
        .exc_cause      (exc_cause),
        .fsm_state      (fsm_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] D = 2'b01;
    localparam logic [1:0] H = 2'b10;

    function automatic logic [14:0] E(input logic [1:0] st,
                                      input logic [1:0] c,
                                      input logic       t,
                                      input logic [4:0] en,
                                      input logic [4:0] bub);
        return {st, c, t, en, bub};
    endfunction

    task automatic push(input string tag, input logic [14:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [14:0] obs;
        obs = {fsm_state, exc_cause, exc_take, stage_en, bubble};
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %h, required a queued entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                n_err++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step(input string tag, input logic [4:0] st,
                        input logic mi, input logic mm, input logic ir,
                        input logic [14:0] v);
        @(posedge clk);
        #1;
        stall_req      = st;
        tlb_miss_instr = mi;
        tlb_miss_mem   = mm;
        iret           = ir;
        push(tag, v);
        @(negedge clk);
        check();
    endtask

    initial begin
        reset          = 1'b0;
        stall_req      = 5'b11111;
        tlb_miss_instr = 1'b1;
        tlb_miss_mem   = 1'b1;
        iret           = 1'b0;
        #2;
        push("rst_init", E(R, 2'b00, 1'b0, 5'b11111, 5'b00000));
        check();
        @(negedge clk);
        stall_req      = '0;
        tlb_miss_instr = 1'b0;
        tlb_miss_mem   = 1'b0;
        reset          = 1'b1;

        step("idle",     5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("stall_k2", 5'b00100, 0, 0, 0, E(R, 0, 0, 5'b11000, 5'b01000));
        step("stall_k4", 5'b10000, 0, 0, 0, E(R, 0, 0, 5'b00000, 5'b00000));
        step("stall_k0", 5'b00001, 0, 0, 0, E(R, 0, 0, 5'b11110, 5'b00010));
        step("stall_k3", 5'b01010, 0, 0, 0, E(R, 0, 0, 5'b10000, 5'b10000));
        step("iret_run", 5'b00000, 0, 0, 1, E(R, 0, 0, 5'b11111, 5'b00000));
        step("iret_aft", 5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));

        step("m_in",     5'b00000, 0, 1, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("m_drain",  5'b00000, 0, 0, 0, E(D, 2, 0, 5'b10000, 5'b10000));
        step("m_take",   5'b00000, 0, 0, 0, E(D, 2, 1, 5'b11111, 5'b11111));
        step("h_ign",    5'b00000, 1, 0, 0, E(H, 2, 0, 5'b11111, 5'b00000));
        step("h_stall",  5'b00010, 1, 1, 0, E(H, 2, 0, 5'b11100, 5'b00100));
        step("h_iret",   5'b00000, 0, 0, 1, E(H, 2, 0, 5'b11111, 5'b00000));

        step("b_in",     5'b00000, 1, 1, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("b_drain",  5'b00000, 0, 0, 0, E(D, 2, 0, 5'b10000, 5'b10000));
        step("b_take",   5'b00000, 0, 0, 0, E(D, 2, 1, 5'b11111, 5'b11111));
        step("b_iret",   5'b00000, 0, 0, 1, E(H, 2, 0, 5'b11111, 5'b00000));

        step("i_in",     5'b00000, 1, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("i_d0",     5'b00001, 0, 0, 0, E(D, 1, 0, 5'b11110, 5'b00010));
        step("i_s1",     5'b10000, 0, 0, 0, E(D, 1, 0, 5'b00000, 5'b00000));
        step("i_s2",     5'b00100, 0, 0, 1, E(D, 1, 0, 5'b11000, 5'b01000));
        step("i_d1",     5'b00000, 0, 0, 0, E(D, 1, 0, 5'b11110, 5'b00010));
        step("i_d2",     5'b00000, 0, 0, 0, E(D, 1, 0, 5'b11110, 5'b00010));
        step("i_d3",     5'b00000, 0, 0, 0, E(D, 1, 0, 5'b11110, 5'b00010));
        step("i_take",   5'b00000, 0, 0, 0, E(D, 1, 1, 5'b11111, 5'b11111));
        step("i_hnd",    5'b00000, 0, 0, 0, E(H, 1, 0, 5'b11111, 5'b00000));

        #2;
        stall_req      = 5'b11111;
        tlb_miss_instr = 1'b1;
        tlb_miss_mem   = 1'b1;
        reset          = 1'b0;
        #1;
        push("rst_hnd", E(R, 0, 0, 5'b11111, 5'b00000));
        check();
        @(posedge clk);
        #1;
        push("rst_hold", E(R, 0, 0, 5'b11111, 5'b00000));
        check();
        @(negedge clk);
        stall_req      = '0;
        tlb_miss_instr = 1'b0;
        tlb_miss_mem   = 1'b0;
        reset          = 1'b1;
        step("post_h0",  5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("post_h1",  5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));

        step("d2_in",    5'b00000, 0, 1, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("d2_drain", 5'b00000, 0, 0, 0, E(D, 2, 0, 5'b10000, 5'b10000));
        #2;
        reset = 1'b0;
        #1;
        push("rst_drain", E(R, 0, 0, 5'b11111, 5'b00000));
        check();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("post_d0",  5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));
        step("post_d1",  5'b00000, 0, 0, 0, E(R, 0, 0, 5'b11111, 5'b00000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
